// File: rtl/mips_alu_pkg.sv
// Shared codes for the ALU control / mul-div unit: ALUop and funct encodings,
// 4-bit ALU control codes and the mul/div sequencer states.
package mips_alu_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_NOR  = 4'b1001,
    ALU_NONE = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide core: one bit per step, magnitudes in, sign-fixed HI/LO out.
// Restoring divider only present when MULDIV_DIV_EN is defined.
module muldiv_iter
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH-1:0]   opnd_reg, acc_hi_reg, acc_lo_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               neg_lo_reg;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod, prod_fix, step_next;

  assign rs_neg = is_signed & rs_val[WIDTH-1];
  assign rt_neg = is_signed & rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  // Shift-add: multiplier sits in acc_lo and is consumed LSB first.
  assign mul_sum  = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_lo_reg[WIDTH-1:1]};
  assign prod     = {acc_hi_reg, acc_lo_reg};
  assign prod_fix = neg_lo_reg ? -prod : prod;

`ifdef MULDIV_DIV_EN
  logic             div_mode_reg, neg_hi_reg, rt_zero, div_ge;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;

  // Divide by zero: every trial subtract succeeds, leaving all-ones quotient and
  // the dividend in the remainder; clearing the quotient sign keeps LO all ones.
  assign rt_zero   = (rt_val == '0);
  assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_reg});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
  assign step_next = div_mode_reg ?
      {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_lo_reg[WIDTH-2:0], div_ge} : mul_next;
  assign res_hi = div_mode_reg ? (neg_hi_reg ? -acc_hi_reg : acc_hi_reg) : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo = div_mode_reg ? (neg_lo_reg ? -acc_lo_reg : acc_lo_reg) : prod_fix[WIDTH-1:0];
`else
  logic unused_div;
  assign unused_div = is_div;
  assign step_next  = mul_next;
  assign res_hi     = prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo     = prod_fix[WIDTH-1:0];
`endif

  assign last = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_reg   <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      cnt_reg    <= '0;
      neg_lo_reg <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_mode_reg <= 1'b0;
      neg_hi_reg   <= 1'b0;
`endif
    end else if (load) begin
      cnt_reg    <= '0;
      acc_hi_reg <= '0;
`ifdef MULDIV_DIV_EN
      div_mode_reg <= is_div;
      neg_hi_reg   <= rs_neg;
      if (is_div) begin
        opnd_reg   <= rt_mag;
        acc_lo_reg <= rs_mag;
        neg_lo_reg <= (rs_neg ^ rt_neg) & ~rt_zero;
      end else begin
        opnd_reg   <= rs_mag;
        acc_lo_reg <= rt_mag;
        neg_lo_reg <= rs_neg ^ rt_neg;
      end
`else
      opnd_reg   <= rs_mag;
      acc_lo_reg <= rt_mag;
      neg_lo_reg <= rs_neg ^ rt_neg;
`endif
    end else if (step) begin
      cnt_reg                  <= cnt_reg + CNT_W'(1);
      {acc_hi_reg, acc_lo_reg} <= step_next;
    end
  end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus HI/LO sequencer driving the iterative mul/div core.
// Define MULDIV_DIV_EN to enable div/divu; otherwise they decode as illegal.
module alu_ctrl_muldiv
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             op_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic             stall,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_ctrl_e        ctrl_sel;
  logic             grp, is_mul, is_div, md_signed, mt_hi, mt_lo;
  logic             accept, start_mul, start_div, step, core_last;
  logic [WIDTH-1:0] res_hi, res_lo, hi_reg, lo_reg;
  md_state_e        state_reg;
  logic             busy_reg;

  always_comb begin
    ctrl_sel  = ALU_ADD;
    illegal   = 1'b0;
    grp       = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    md_signed = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    case (alu_op)
      ALUOP_ADD: ctrl_sel = ALU_ADD;
      ALUOP_SUB: ctrl_sel = ALU_SUB;
      ALUOP_AND: ctrl_sel = ALU_AND;
      ALUOP_OR:  ctrl_sel = ALU_OR;
      ALUOP_SLT: ctrl_sel = ALU_SLT;
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD: ctrl_sel = ALU_ADD;
          F_SUB: ctrl_sel = ALU_SUB;
          F_AND: ctrl_sel = ALU_AND;
          F_OR:  ctrl_sel = ALU_OR;
          F_NOR: ctrl_sel = ALU_NOR;
          F_SLT: ctrl_sel = ALU_SLT;
          F_SLL: ctrl_sel = ALU_SLL;
          F_SRL: ctrl_sel = ALU_SRL;
          F_SRA: ctrl_sel = ALU_SRA;
          F_XOR: ctrl_sel = ALU_XOR;
          F_MULT, F_MULTU: begin
            ctrl_sel  = ALU_NONE;
            grp       = 1'b1;
            is_mul    = 1'b1;
            md_signed = (funct == F_MULT);
          end
`ifdef MULDIV_DIV_EN
          F_DIV, F_DIVU: begin
            ctrl_sel  = ALU_NONE;
            grp       = 1'b1;
            is_div    = 1'b1;
            md_signed = (funct == F_DIV);
          end
`endif
          F_MFHI, F_MFLO: begin
            ctrl_sel = ALU_NONE;
            grp      = 1'b1;
          end
          F_MTHI: begin
            ctrl_sel = ALU_NONE;
            grp      = 1'b1;
            mt_hi    = 1'b1;
          end
          F_MTLO: begin
            ctrl_sel = ALU_NONE;
            grp      = 1'b1;
            mt_lo    = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign alu_control = ctrl_sel;
  assign stall       = op_valid & grp & busy_reg;
  assign accept      = op_valid & grp & ~busy_reg & ~flush;
  assign start_mul   = accept & is_mul;
  assign start_div   = accept & is_div;
  assign step        = (state_reg == ST_MUL) || (state_reg == ST_DIV);
  assign md_busy     = busy_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start_mul | start_div),
    .step      (step),
    .is_div    (is_div),
    .is_signed (md_signed),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .last      (core_last),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // Busy spans MUL/DIV (WIDTH cycles) plus DONE; HI/LO commit as busy drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (mt_hi) hi_reg <= rs_val;
            if (mt_lo) lo_reg <= rs_val;
            if (start_mul) begin
              state_reg <= ST_MUL;
              busy_reg  <= 1'b1;
            end else if (start_div) begin
              state_reg <= ST_DIV;
              busy_reg  <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (flush) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (core_last) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          if (!flush) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Randomised self-checking bench for alu_ctrl_muldiv against an arithmetic reference model.
// Division checks are built only when MULDIV_DIV_EN is defined; otherwise div must decode illegal.
module tb_alu_ctrl_muldiv;

  localparam logic [5:0] T_MULT = 6'b011000, T_MULTU = 6'b011001;
  localparam logic [5:0] T_DIV  = 6'b011010, T_DIVU  = 6'b011011;
  localparam logic [5:0] T_MFLO = 6'b010010, T_MTHI  = 6'b010001, T_MTLO = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic        op_valid, flush;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  alu_control;
  logic        illegal, stall, md_busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  alu_ctrl_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct(funct), .op_valid(op_valid),
    .flush(flush), .rs_val(rs_val), .rt_val(rt_val), .alu_control(alu_control),
    .illegal(illegal), .stall(stall), .md_busy(md_busy), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // {illegal, alu_control} straight from the decode table
  function automatic logic [4:0] ref_decode(input logic [2:0] op, input logic [5:0] f);
    case (op)
      3'd0: return 5'h00;
      3'd1: return 5'h01;
      3'd3: return 5'h02;
      3'd4: return 5'h03;
      3'd5: return 5'h08;
      3'd2: begin
        case (f)
          6'd32: return 5'h00;
          6'd34: return 5'h01;
          6'd36: return 5'h02;
          6'd37: return 5'h03;
          6'd39: return 5'h09;
          6'd42: return 5'h08;
          6'd0:  return 5'h04;
          6'd2:  return 5'h05;
          6'd3:  return 5'h06;
          6'd38: return 5'h07;
          6'd24, 6'd25, 6'd16, 6'd17, 6'd18, 6'd19: return 5'h0F;
`ifdef MULDIV_DIV_EN
          6'd26, 6'd27: return 5'h0F;
`endif
          default: return 5'h10;
        endcase
      end
      default: return 5'h10;
    endcase
  endfunction

  task automatic ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    int q, r;
    h = '0;
    l = '0;
    if (f == T_MULT) begin
      p = longint'($signed(a)) * longint'($signed(b));
      h = p[63:32];
      l = p[31:0];
    end else if (f == T_MULTU) begin
      p = {32'b0, a} * {32'b0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      l = 32'hFFFF_FFFF;
      h = a;
    end else if (f == T_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        l = a;
        h = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        l = q;
        h = r;
      end
    end else begin
      l = a / b;
      h = a % b;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] sp[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 20));
      2: return -32'($urandom_range(1, 20));
      default: return sp[$urandom_range(0, 4)];
    endcase
  endfunction

  // Issue a mul/div, then hold mflo valid and count the stalled cycles.
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int cycles;
    logic stall_ok;
    ref_md(f, a, b, eh, el);
    @(negedge clk);
    alu_op = 3'b010; funct = f; rs_val = a; rt_val = b; op_valid = 1'b1;
    #1 check($sformatf("start_stall f=%0h", f), stall, 0);
    @(posedge clk);
    #1 funct = T_MFLO;
    @(negedge clk);
    cycles = 0;
    stall_ok = 1'b1;
    while (md_busy === 1'b1 && cycles < 100) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      cycles++;
      @(negedge clk);
    end
    m_hi = eh;
    m_lo = el;
    check($sformatf("busy_cycles f=%0h", f), cycles, 33);
    check($sformatf("stall_held f=%0h", f), stall_ok, 1);
    check($sformatf("stall_release f=%0h", f), stall, 0);
    check($sformatf("hi f=%0h a=%h b=%h", f, a, b), hi, m_hi);
    check($sformatf("lo f=%0h a=%h b=%h", f, a, b), lo, m_lo);
    op_valid = 1'b0;
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] v);
    @(negedge clk);
    alu_op = 3'b010; funct = f; rs_val = v; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    if (f == T_MTHI) m_hi = v;
    else m_lo = v;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  initial begin
    logic [5:0] ops[$];
    logic [5:0] fsel;
    alu_op = '0; funct = '0; op_valid = 1'b0; flush = 1'b0;
    rs_val = '0; rt_val = '0; rst_n = 1'b0;

    repeat (2) @(negedge clk);
    alu_op = 3'b010; funct = T_MFLO; op_valid = 1'b1;
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", md_busy, 0);
    check("rst_stall", stall, 0);
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int op = 0; op < 8; op++) begin
      int nf;
      nf = (op == 2) ? 64 : 2;
      for (int f = 0; f < nf; f++) begin
        alu_op = 3'(op);
        funct  = (op == 2) ? 6'(f) : 6'($urandom_range(0, 63));
        #1 check($sformatf("decode op=%0d f=%0d", op, funct), {illegal, alu_control},
                 ref_decode(alu_op, funct));
      end
    end

    mt(T_MTHI, 32'h1234);
    mt(T_MTLO, 32'h5678);

    run_md(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md(T_MULT, -32'd7, 32'd3);
    ops.push_back(T_MULT);
    ops.push_back(T_MULTU);
`ifdef MULDIV_DIV_EN
    run_md(T_DIV, -32'd7, 32'd2);
    run_md(T_DIVU, 32'd5, 32'd0);
    run_md(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md(T_DIV, -32'd9, 32'd0);
    ops.push_back(T_DIV);
    ops.push_back(T_DIVU);
`else
    @(negedge clk);
    alu_op = 3'b010; funct = T_DIV; rs_val = 32'd7; rt_val = 32'd2; op_valid = 1'b1;
    #1 check("nodiv_decode", {illegal, alu_control}, 5'h10);
    @(negedge clk);
    op_valid = 1'b0;
    check("nodiv_busy", md_busy, 0);
`endif

    for (int i = 0; i < 12; i++)
      run_md(ops[$urandom_range(0, ops.size() - 1)], pick_operand(), pick_operand());

    // flush with a start in the same cycle, and a flushed mthi
    @(negedge clk);
    alu_op = 3'b010; funct = T_MULT; rs_val = 32'd3; rt_val = 32'd4; op_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_start_busy", md_busy, 0);
    funct = T_MTHI; rs_val = 32'hDEAD;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    check("flush_mthi", hi, m_hi);

    mt(T_MTHI, 32'h1234);
`ifdef MULDIV_DIV_EN
    fsel = T_DIV;
`else
    fsel = T_MULT;
`endif
    @(negedge clk);
    alu_op = 3'b010; funct = fsel; rs_val = 32'd1000; rt_val = 32'd7; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", md_busy, 0);
    check("flush_hi", hi, 32'h1234);
    check("flush_lo", lo, m_lo);
    repeat (40) @(negedge clk);
    check("flush_late_hi", hi, m_hi);
    check("flush_late_lo", lo, m_lo);

    run_md(T_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    alu_op = 3'b010; funct = T_MULTU; rs_val = 32'hFFFF; rt_val = 32'hFFFF; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", md_busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    run_md(T_MULT, 32'h7FFF_FFFF, 32'h8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
